// File: rtl/scie_cfir_pipelined_if.sv
// Instruction/result bundle between the core and the SCIE complex FIR unit.
//   io_valid / io_ready          : instruction handshake (accept = valid & ready)
//   io_insn                      : instruction word, [6:0] opcode, [14:12] funct3
//   io_rs1_real / io_rs1_imag    : signed complex operand (sample or coefficient)
//   io_rs2                       : coefficient index for LOAD_COEF
//   io_rd_real / io_rd_imag      : signed complex result, updated by READ
//   io_rd_valid                  : one-cycle pulse after a READ is accepted
// master = core side, slave = FIR unit side.
interface scie_cfir_pipelined_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned OUT_W = 16
) ();
  logic                    io_valid;
  logic                    io_ready;
  logic [31:0]             io_insn;
  logic signed [W-1:0]     io_rs1_real;
  logic signed [W-1:0]     io_rs1_imag;
  logic [31:0]             io_rs2;
  logic signed [OUT_W-1:0] io_rd_real;
  logic signed [OUT_W-1:0] io_rd_imag;
  logic                    io_rd_valid;

  modport master (
    output io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
    input  io_ready, io_rd_real, io_rd_imag, io_rd_valid
  );

  modport slave (
    input  io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
    output io_ready, io_rd_real, io_rd_imag, io_rd_valid
  );
endinterface

// File: rtl/scie_cfir_pipelined.sv
// SCIE complex FIR custom-instruction unit, two-stage pipeline.
// Holds a TAPS-deep complex coefficient bank and a complex delay line.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   io    : instruction/result bundle (slave side), see scie_cfir_pipelined_if
// Opcodes: 0x0B LOAD_COEF, 0x2B PUSH, 0x5B READ, 0x7B CLEAR; others are ignored.
// PUSH registers the per-tap products (stage 0); the following cycle sums, scales
// by funct3, saturates/wraps and writes the result register (stage 1).
// Requires OUT_W <= 2*W + log2(TAPS) + 1.
module scie_cfir_pipelined #(
  parameter int unsigned W        = 16,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned TAPS     = 4,
  parameter int unsigned SATURATE = 1
) (
  input logic                  clock,
  input logic                  reset,
  scie_cfir_pipelined_if.slave io
);

  localparam int unsigned LogTaps = $clog2(TAPS);
  localparam int unsigned ProdW   = 2 * W + 1;
  localparam int unsigned AccW    = 2 * W + LogTaps + 1;

  localparam logic [6:0] OpLoad  = 7'h0B;
  localparam logic [6:0] OpPush  = 7'h2B;
  localparam logic [6:0] OpRead  = 7'h5B;
  localparam logic [6:0] OpClear = 7'h7B;

  localparam logic signed [AccW-1:0] SatMax = {{(AccW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [LogTaps-1:0] idx;
  logic               ready;
  logic               accept;

  logic signed [W-1:0] x_re_q [TAPS];
  logic signed [W-1:0] x_re_d [TAPS];
  logic signed [W-1:0] x_im_q [TAPS];
  logic signed [W-1:0] x_im_d [TAPS];
  logic signed [W-1:0] coef_re_q [TAPS];
  logic signed [W-1:0] coef_re_d [TAPS];
  logic signed [W-1:0] coef_im_q [TAPS];
  logic signed [W-1:0] coef_im_d [TAPS];

  logic signed [ProdW-1:0] prod_re_q [TAPS];
  logic signed [ProdW-1:0] prod_re_d [TAPS];
  logic signed [ProdW-1:0] prod_im_q [TAPS];
  logic signed [ProdW-1:0] prod_im_d [TAPS];
  logic                    s1_valid_q, s1_valid_d;
  logic [2:0]              s1_shift_q, s1_shift_d;

  logic signed [AccW-1:0]  acc_re, acc_im;
  logic signed [AccW-1:0]  sh_re, sh_im;

  logic signed [OUT_W-1:0] res_re_q, res_re_d;
  logic signed [OUT_W-1:0] res_im_q, res_im_d;
  logic signed [OUT_W-1:0] rd_re_q, rd_re_d;
  logic signed [OUT_W-1:0] rd_im_q, rd_im_d;
  logic                    rd_valid_q, rd_valid_d;

  logic unused_bits;

  assign opcode      = io.io_insn[6:0];
  assign funct3      = io.io_insn[14:12];
  assign idx         = io.io_rs2[LogTaps-1:0];
  assign unused_bits = ^{io.io_insn[31:15], io.io_insn[11:7], io.io_rs2[31:LogTaps]};

  // A READ must wait for a PUSH still in the summation stage.
  assign ready  = !(s1_valid_q && io.io_valid && (opcode == OpRead));
  assign accept = io.io_valid && ready;

  function automatic logic signed [OUT_W-1:0] fit(input logic signed [AccW-1:0] v);
    if ((SATURATE != 0) && (v > SatMax)) begin
      return SatMax[OUT_W-1:0];
    end else if ((SATURATE != 0) && (v < SatMin)) begin
      return SatMin[OUT_W-1:0];
    end
    return v[OUT_W-1:0];
  endfunction

  // Stage 1: sum the registered products and scale.
  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_re = acc_re + AccW'(prod_re_q[k]);
      acc_im = acc_im + AccW'(prod_im_q[k]);
    end
    sh_re = acc_re >>> s1_shift_q;
    sh_im = acc_im >>> s1_shift_q;
  end

  always_comb begin
    x_re_d     = x_re_q;
    x_im_d     = x_im_q;
    coef_re_d  = coef_re_q;
    coef_im_d  = coef_im_q;
    prod_re_d  = prod_re_q;
    prod_im_d  = prod_im_q;
    s1_valid_d = 1'b0;
    s1_shift_d = s1_shift_q;
    res_re_d   = res_re_q;
    res_im_d   = res_im_q;
    rd_re_d    = rd_re_q;
    rd_im_d    = rd_im_q;
    rd_valid_d = 1'b0;

    if (s1_valid_q) begin
      res_re_d = fit(sh_re);
      res_im_d = fit(sh_im);
    end

    if (accept) begin
      case (opcode)
        OpLoad: begin
          coef_re_d[idx] = io.io_rs1_real;
          coef_im_d[idx] = io.io_rs1_imag;
        end
        OpPush: begin
          for (int k = TAPS - 1; k > 0; k--) begin
            x_re_d[k] = x_re_q[k-1];
            x_im_d[k] = x_im_q[k-1];
          end
          x_re_d[0]  = io.io_rs1_real;
          x_im_d[0]  = io.io_rs1_imag;
          s1_valid_d = 1'b1;
          s1_shift_d = funct3;
          // Products use the post-shift delay line and current coefficients.
          for (int k = 0; k < TAPS; k++) begin
            prod_re_d[k] = ProdW'(x_re_d[k]) * ProdW'(coef_re_q[k])
                         - ProdW'(x_im_d[k]) * ProdW'(coef_im_q[k]);
            prod_im_d[k] = ProdW'(x_re_d[k]) * ProdW'(coef_im_q[k])
                         + ProdW'(x_im_d[k]) * ProdW'(coef_re_q[k]);
          end
        end
        OpRead: begin
          rd_re_d    = res_re_q;
          rd_im_d    = res_im_q;
          rd_valid_d = 1'b1;
        end
        OpClear: begin
          for (int k = 0; k < TAPS; k++) begin
            x_re_d[k] = '0;
            x_im_d[k] = '0;
          end
          // Overrides any in-flight summation above.
          res_re_d = '0;
          res_im_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x_re_q[k]    <= '0;
        x_im_q[k]    <= '0;
        coef_re_q[k] <= '0;
        coef_im_q[k] <= '0;
        prod_re_q[k] <= '0;
        prod_im_q[k] <= '0;
      end
      s1_valid_q <= 1'b0;
      s1_shift_q <= '0;
      res_re_q   <= '0;
      res_im_q   <= '0;
      rd_re_q    <= '0;
      rd_im_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      x_re_q     <= x_re_d;
      x_im_q     <= x_im_d;
      coef_re_q  <= coef_re_d;
      coef_im_q  <= coef_im_d;
      prod_re_q  <= prod_re_d;
      prod_im_q  <= prod_im_d;
      s1_valid_q <= s1_valid_d;
      s1_shift_q <= s1_shift_d;
      res_re_q   <= res_re_d;
      res_im_q   <= res_im_d;
      rd_re_q    <= rd_re_d;
      rd_im_q    <= rd_im_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign io.io_ready    = ready;
  assign io.io_rd_real  = rd_re_q;
  assign io.io_rd_imag  = rd_im_q;
  assign io.io_rd_valid = rd_valid_q;

endmodule

// File: doc/scie_cfir_pipelined.md
Name: scie_cfir_pipelined

Overview:
Parametrised successor to the single-lane SCIE complex FIR custom-instruction unit. It sits beside the core as a RISC-V custom-0/1/2/3 accelerator and holds a TAPS-deep complex coefficient bank and a complex sample delay line. It computes the complex FIR dot-product in a two-stage pipeline with per-instruction scaling, saturation, a valid/ready handshake and a read-stall interlock.

Parameters:
W, 16, signed width of each real/imag input component
OUT_W, 16, signed width of each result component
TAPS, 4, number of coefficients / delay-line entries (power of two, >=2)
SATURATE, 1, 1 = clamp result to OUT_W range; 0 = two's-complement wrap (truncate)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
io_valid  in  1  instruction present
io_ready  out  1  unit can accept instruction this cycle
io_insn  in  32  instruction word; [6:0] opcode, [14:12] funct3
io_rs1_real  in  W  signed real part of rs1 operand
io_rs1_imag  in  W  signed imag part of rs1 operand
io_rs2  in  32  rs2 operand (coefficient index)
io_rd_real  out  OUT_W  signed real result
io_rd_imag  out  OUT_W  signed imag result
io_rd_valid  out  1  one-cycle pulse: io_rd_* updated by a READ

Behaviour:
- Accept = io_valid & io_ready, sampled at the rising edge.
- Opcodes:
  - 0x0B LOAD_COEF: coef[rs2 mod TAPS] <= rs1. Takes effect the next cycle.
  - 0x2B PUSH: shift the delay line (x[k] <= x[k-1]), x[0] <= rs1, then launch the FIR.
  - 0x5B READ: io_rd <= result register.
  - 0x7B CLEAR: zero delay line, result register and pipeline valids. Coefficients are retained.
  - Any other opcode is accepted and ignored.
- FIR: y = sum over k of x[k]*coef[k], using the delay line after the shift.
  - Complex product: re = a.re*b.re - a.im*b.im; im = a.re*b.im + a.im*b.re.
  - Internal width 2W+log2(TAPS)+1. No overflow is possible internally.
- Pipeline:
  - PUSH accepted in cycle n: the product array is registered at the end of n (s1_valid=1 in n+1).
  - The sum is formed in n+1, arithmetic-shifted right by funct3 of that PUSH (0..7, carried with s1), saturated or wrapped to OUT_W, and written to the result register at the end of n+1.
  - Throughput is one PUSH per cycle. Back-to-back PUSHes each use their own snapshot of delay line and coefficients.
- Interlock: io_ready = !(s1_valid & io_valid & opcode==READ).
  - A READ presented while a PUSH is in s1 stalls exactly one cycle.
  - All other opcodes are never stalled.
- READ accepted in cycle m: io_rd_real/imag are updated at the end of m and held until the next READ. io_rd_valid=1 during m+1 only.
- Saturation: a value > 2^(OUT_W-1)-1 clamps to max; a value < -2^(OUT_W-1) clamps to min. Applied independently to real and imag.
- LOAD_COEF in the same cycle as s1 summation does not affect the in-flight result; products are already registered.
- LOAD_COEF and PUSH are never simultaneous: one instruction per cycle.
- CLEAR while s1_valid: the in-flight result is discarded, and the result register reads 0.
- Reset (async assert, sync deassert by the integrator) clears:
  - the delay line, coefficients, s1_valid and the result register;
  - io_rd_real=0, io_rd_imag=0, io_rd_valid=0;
  - io_ready=1 once io_valid is low.
- Reset asserted mid-pipeline: in-flight work is lost; there is no partial update.

Test Plan:
- Legacy sequence (TAPS=4, funct3=0):
  - LOAD_COEF idx0=12-35j, then idx1=35-5j; PUSH 40+30j; idle; READ -> next cycle rd=1530-1040j, io_rd_valid pulse.
  - PUSH 15-2j; idle; READ -> rd=1660+301j.
- Stall: PUSH 40+30j (coef0=12-35j) immediately followed by READ.
  - Expected: io_ready=0 for one cycle, READ accepted the next cycle, rd=1530-1040j.
  - Expected: no extra io_rd_valid pulse.
- Scaling and saturation:
  - coef0=1000+0j, PUSH 100+0j, funct3=0 -> rd.real=32767 (clamped).
  - Same with funct3=2 -> 25000.
  - With SATURATE=0 and funct3=0, 100000 mod 2^16 -> -31072.
- Index wrap and delay depth:
  - LOAD_COEF rs2=5 writes idx1.
  - Five PUSHes of 1+0j with all coef=1+0j -> rd=4+0j; the oldest sample falls off.
- CLEAR: after a non-zero result, CLEAR then READ -> rd=0+0j. A subsequent PUSH 40+30j -> 1530-1040j (coefficients retained).
- Reset mid-operation: assert reset the cycle after a PUSH.
  - During reset: all outputs 0.
  - After release, READ -> 0+0j, and PUSH of any value -> 0+0j (coefficients cleared).
